// File: rtl/spio_spinnaker_link_receiver_pkg.sv
// SpiNNaker link constants (packet width, 2-of-7 codes, nibble counts) and the
// symbol decoder shared by the link receiver.
package spio_spinnaker_link_receiver_pkg;

    localparam int PKT_BITS      = 72;
    localparam int SHORT_NIBBLES = 10;
    localparam int LONG_NIBBLES  = 18;

    localparam logic [6:0] CODE_EOP = 7'h60;

    // Index i holds the transition pattern that encodes nibble i.
    localparam logic [15:0][6:0] NIBBLE_CODE = {
        7'h09, 7'h0C, 7'h06, 7'h03,
        7'h48, 7'h44, 7'h42, 7'h41,
        7'h28, 7'h24, 7'h22, 7'h21,
        7'h18, 7'h14, 7'h12, 7'h11
    };

    typedef enum logic [1:0] {
        SYM_NONE   = 2'd0,
        SYM_NIBBLE = 2'd1,
        SYM_EOP    = 2'd2,
        SYM_ERROR  = 2'd3
    } sym_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_WAITEOP = 2'd2,
        ST_FLUSH   = 2'd3
    } rx_state_e;

    typedef struct packed {
        sym_kind_e  kind;
        logic [3:0] nibble;
    } sym_t;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    function automatic sym_t decode_2of7(input logic [6:0] diff);
        sym_t sym;
        sym.kind   = SYM_NONE;
        sym.nibble = 4'h0;
        if (popcount7(diff) < 3'd2) begin
            sym.kind = SYM_NONE;
        end else if (diff == CODE_EOP) begin
            sym.kind = SYM_EOP;
        end else begin
            sym.kind = SYM_ERROR;
            for (int i = 0; i < 16; i++) begin
                if (diff == NIBBLE_CODE[i]) begin
                    sym.kind   = SYM_NIBBLE;
                    sym.nibble = 4'(i);
                end
            end
        end
        return sym;
    endfunction

    // Packets carry odd parity: the XOR of every assembled bit must be 1.
    function automatic logic odd_parity_ok(input logic [PKT_BITS-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_sync.sv
// Multi-bit flip-flop synchroniser with asynchronous active-high reset; used
// for the 2-of-7 data lines here and for ack on the transmit side.
module spio_spinnaker_link_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/spio_spinnaker_link_receiver.sv
// SpiNNaker link receiver: 2-of-7 NRZ symbol decode, packet assembly and
// valid/ready delivery. Optional odd-parity drop: SPIO_SPINNAKER_LINK_RX_PARITY_EN.
module spio_spinnaker_link_receiver
    import spio_spinnaker_link_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          data_2of7,
    output logic                ack,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic                pkt_vld,
    input  logic                pkt_rdy,
    output logic                ctr_pkt,
    output logic                ctr_flt,
    output logic                ctr_perr
);

    logic [6:0]          sync_s;
    logic [6:0]          old_code_r;
    sym_t                sym_s;
    rx_state_e           state_r;
    rx_state_e           state_nxt_s;
    logic                ack_r;
    logic [4:0]          cnt_r;
    logic                long_r;
    logic [PKT_BITS-1:0] asm_r;
    logic [PKT_BITS-1:0] pkt_data_r;
    logic                pkt_vld_r;
    logic                ctr_pkt_r;
    logic                ctr_flt_r;
    logic                ctr_perr_r;
    logic [4:0]          expected_cnt_s;
    logic                last_nibble_s;
    logic                out_free_s;
    logic                parity_ok_s;
    logic                accept_s;
    logic                store_s;
    logic                first_s;
    logic                load_s;
    logic                flt_s;
    logic                perr_s;

    spio_spinnaker_link_sync #(
        .WIDTH  (7),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_2of7),
        .q   (sync_s)
    );

    assign sym_s          = decode_2of7(sync_s ^ old_code_r);
    assign expected_cnt_s = long_r ? 5'(LONG_NIBBLES) : 5'(SHORT_NIBBLES);
    assign last_nibble_s  = (cnt_r + 5'd1) == expected_cnt_s;
    assign out_free_s     = !pkt_vld_r || pkt_rdy;

`ifdef SPIO_SPINNAKER_LINK_RX_PARITY_EN
    assign parity_ok_s = odd_parity_ok(asm_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Framing FSM: pick the next state and the per-symbol actions.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        store_s     = 1'b0;
        first_s     = 1'b0;
        load_s      = 1'b0;
        flt_s       = 1'b0;
        perr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (sym_s.kind)
                    SYM_NIBBLE: begin
                        accept_s    = 1'b1;
                        store_s     = 1'b1;
                        first_s     = 1'b1;
                        state_nxt_s = ST_RECV;
                    end
                    SYM_EOP: begin
                        accept_s = 1'b1;
                        flt_s    = 1'b1;
                    end
                    SYM_ERROR: begin
                        accept_s    = 1'b1;
                        flt_s       = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_RECV: begin
                case (sym_s.kind)
                    SYM_NIBBLE: begin
                        accept_s = 1'b1;
                        store_s  = 1'b1;
                        if (last_nibble_s) begin
                            state_nxt_s = ST_WAITEOP;
                        end else begin
                            state_nxt_s = ST_RECV;
                        end
                    end
                    SYM_EOP: begin
                        accept_s    = 1'b1;
                        flt_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    SYM_ERROR: begin
                        accept_s    = 1'b1;
                        flt_s       = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_WAITEOP: begin
                case (sym_s.kind)
                    SYM_EOP: begin
                        // An EOP left unacked is what back-pressures the sender.
                        if (out_free_s) begin
                            accept_s    = 1'b1;
                            state_nxt_s = ST_IDLE;
                            if (parity_ok_s) begin
                                load_s = 1'b1;
                            end else begin
                                perr_s = 1'b1;
                            end
                        end else begin
                            state_nxt_s = ST_WAITEOP;
                        end
                    end
                    SYM_NIBBLE, SYM_ERROR: begin
                        accept_s    = 1'b1;
                        flt_s       = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            ST_FLUSH: begin
                case (sym_s.kind)
                    SYM_EOP: begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    SYM_NIBBLE, SYM_ERROR: begin
                        accept_s = 1'b1;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Framing FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Symbol handshake, packet assembly, output register and counter strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_code_r <= 7'h00;
            ack_r      <= 1'b0;
            cnt_r      <= 5'd0;
            long_r     <= 1'b0;
            asm_r      <= {PKT_BITS{1'b0}};
            pkt_data_r <= {PKT_BITS{1'b0}};
            pkt_vld_r  <= 1'b0;
            ctr_pkt_r  <= 1'b0;
            ctr_flt_r  <= 1'b0;
            ctr_perr_r <= 1'b0;
        end else begin
            ctr_pkt_r  <= load_s;
            ctr_flt_r  <= flt_s;
            ctr_perr_r <= perr_s;
            if (accept_s) begin
                old_code_r <= sync_s;
                ack_r      <= ~ack_r;
            end
            if (store_s) begin
                if (first_s) begin
                    asm_r  <= {{(PKT_BITS-4){1'b0}}, sym_s.nibble};
                    cnt_r  <= 5'd1;
                    long_r <= sym_s.nibble[1];
                end else begin
                    asm_r[{cnt_r, 2'b00} +: 4] <= sym_s.nibble;
                    cnt_r                      <= cnt_r + 5'd1;
                end
            end
            if (load_s) begin
                pkt_data_r <= asm_r;
                pkt_vld_r  <= 1'b1;
            end else if (pkt_rdy) begin
                pkt_vld_r <= 1'b0;
            end
        end
    end

    assign ack      = ack_r;
    assign pkt_data = pkt_data_r;
    assign pkt_vld  = pkt_vld_r;
    assign ctr_pkt  = ctr_pkt_r;
    assign ctr_flt  = ctr_flt_r;
    assign ctr_perr = ctr_perr_r;

endmodule

// File: tb/tb_spio_spinnaker_link_receiver.sv
// Scoreboard bench for spio_spinnaker_link_receiver: a 2-of-7 NRZ transmitter
// model drives packets; a monitor checks every delivered packet and counts strobes.
module tb_spio_spinnaker_link_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  data_2of7 = 7'h00;
    logic        ack;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy = 1'b1;
    logic        ctr_pkt;
    logic        ctr_flt;
    logic        ctr_perr;

    always #5 clk = ~clk;

    spio_spinnaker_link_receiver #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_2of7 (data_2of7),
        .ack       (ack),
        .pkt_data  (pkt_data),
        .pkt_vld   (pkt_vld),
        .pkt_rdy   (pkt_rdy),
        .ctr_pkt   (ctr_pkt),
        .ctr_flt   (ctr_flt),
        .ctr_perr  (ctr_perr)
    );

    localparam logic [6:0] EOP = 7'h60;
    logic [6:0] nib_code [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                                  7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09};

    int errors = 0;
    int checks = 0;
    logic [71:0] exp_q [$];
    int n_pkt = 0, n_flt = 0, n_perr = 0, n_ack = 0;
    int exp_pkt = 0, exp_flt = 0, exp_perr = 0;
    logic ack_seen = 1'b0;
    logic ack_exp  = 1'b0;
    logic rdy_rand = 1'b0;
    logic rdy_set  = 1'b1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit deliver_ok(input logic [71:0] m);
`ifdef SPIO_SPINNAKER_LINK_RX_PARITY_EN
        return ^m;
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: count ack toggles and strobes, check each consumed packet.
    always @(negedge clk) begin
        if (ack !== ack_seen) begin
            n_ack++;
            ack_seen = ack;
        end
        if (ctr_pkt === 1'b1) n_pkt++;
        if (ctr_flt === 1'b1) n_flt++;
        if (ctr_perr === 1'b1) n_perr++;
        if (pkt_vld === 1'b1 && pkt_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got %h expected none", pkt_data);
            end else begin
                check("pkt_data", pkt_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #2;
        pkt_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_set;
    end

    task automatic put_sym(input logic [6:0] code);
        @(posedge clk);
        #2;
        data_2of7 = data_2of7 ^ code;
    endtask

    task automatic wait_ack(input string name);
        int i;
        ack_exp = ~ack_exp;
        i = 0;
        while (ack !== ack_exp && i < 200) begin
            @(posedge clk);
            #2;
            i++;
        end
        check(name, ack, ack_exp);
        ack_exp = ack;
    endtask

    task automatic send_sym(input logic [6:0] code, input string name);
        put_sym(code);
        wait_ack(name);
    endtask

    task automatic send_packet(input logic [71:0] v, input int skew, input bit hold_eop);
        logic [71:0] m;
        logic [6:0]  c, lo;
        int n;
        m = v;
        n = v[1] ? 18 : 10;
        if (n == 10) m[71:40] = 32'h0;
        for (int i = 0; i < n; i++) begin
            c = nib_code[m[4*i +: 4]];
            if (i == 0 && skew > 0) begin
                lo = c & (~c + 7'd1);
                put_sym(lo);
                repeat (skew) @(posedge clk);
                #2;
                data_2of7 = data_2of7 ^ (c ^ lo);
                wait_ack("ack_skew");
            end else begin
                send_sym(c, "ack_nibble");
            end
        end
        if (deliver_ok(m)) begin
            exp_q.push_back(m);
            exp_pkt++;
        end else begin
            exp_perr++;
        end
        if (hold_eop) put_sym(EOP);
        else send_sym(EOP, "ack_eop");
    endtask

    task automatic settle(input bit drained);
        repeat (6) @(posedge clk);
        #2;
        check("ctr_pkt_count", n_pkt, exp_pkt);
        check("ctr_flt_count", n_flt, exp_flt);
        check("ctr_perr_count", n_perr, exp_perr);
        if (drained) check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int a0;
        logic a_lvl;
        logic [71:0] rv;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack", ack, 72'h0);
        check("rst_pkt_vld", pkt_vld, 72'h0);
        check("rst_pkt_data", pkt_data, 72'h0);
        check("rst_ctr_pkt", ctr_pkt, 72'h0);
        check("rst_ctr_flt", ctr_flt, 72'h0);
        check("rst_ctr_perr", ctr_perr, 72'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Short and long packets with the consumer always ready.
        a0 = n_ack;
        send_packet(72'h00_0000_0000_1234_5678, 0, 1'b0);
        settle(1'b1);
        check("short_ack_toggles", n_ack - a0, 72'd11);
        a0 = n_ack;
        send_packet(72'hAB_CDEF_0123_4567_89A2, 0, 1'b0);
        settle(1'b1);
        check("long_ack_toggles", n_ack - a0, 72'd19);

        // Back-pressure: second EOP stays unacked while the first packet is held.
        rdy_set = 1'b0;
        repeat (3) @(posedge clk);
        send_packet(72'h00_0000_00F0_0000_0008, 0, 1'b0);
        settle(1'b0);
        check("bp_vld_held", pkt_vld, 72'h1);
        check("bp_data_held", pkt_data, 72'h00_0000_00F0_0000_0008);
        send_packet(72'h00_0000_000E_0000_0009, 0, 1'b1);
        a_lvl = ack;
        repeat (120) @(posedge clk);
        #2;
        check("bp_eop_unacked", ack, a_lvl);
        check("bp_data_stable", pkt_data, 72'h00_0000_00F0_0000_0008);
        rdy_set = 1'b1;
        wait_ack("bp_eop_released");
        settle(1'b1);

        // Framing faults: stray EOP, early EOP, illegal code, overlong, 3-bit code.
        send_sym(EOP, "ack_stray_eop");
        exp_flt++;
        settle(1'b1);
        for (int i = 0; i < 5; i++) send_sym(nib_code[$urandom_range(0, 15)], "ack_nibble");
        send_sym(EOP, "ack_early_eop");
        exp_flt++;
        settle(1'b1);
        check("early_no_vld", pkt_vld, 72'h0);
        send_packet({$urandom, $urandom, $urandom}, 0, 1'b0);
        settle(1'b1);
        send_sym(7'h30, "ack_illegal");
        exp_flt++;
        for (int i = 0; i < 4; i++) send_sym(nib_code[$urandom_range(0, 15)], "ack_flush");
        send_sym(7'h07, "ack_flush_err");
        send_sym(EOP, "ack_flush_eop");
        settle(1'b1);
        for (int i = 0; i < 10; i++) send_sym(nib_code[i == 0 ? 0 : $urandom_range(0, 15)], "ack_nibble");
        send_sym(nib_code[3], "ack_overlong");
        exp_flt++;
        send_sym(EOP, "ack_flush_eop");
        settle(1'b1);
        for (int i = 0; i < 3; i++) send_sym(nib_code[$urandom_range(0, 15)], "ack_nibble");
        send_sym(7'h07, "ack_popcount3");
        exp_flt++;
        send_sym(EOP, "ack_flush_eop");
        settle(1'b1);
        send_packet({$urandom, $urandom, $urandom}, 0, 1'b0);
        settle(1'b1);

        // Skewed arrival of the two bits of the first symbol.
        a0 = n_ack;
        send_packet(72'h00_0000_0012_3456_7890, 3, 1'b0);
        settle(1'b1);
        check("skew_ack_toggles", n_ack - a0, 72'd11);

        // Reset mid-packet while a packet is held in the output register.
        rdy_set = 1'b0;
        repeat (3) @(posedge clk);
        send_packet(72'h00_0000_00F0_0000_0008, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_sym(nib_code[$urandom_range(0, 15)], "ack_nibble");
        settle(1'b0);
        check("pre_rst_vld", pkt_vld, 72'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_ack", ack, 72'h0);
        check("mid_rst_vld", pkt_vld, 72'h0);
        data_2of7 = 7'h00;
        ack_exp = 1'b0;
        exp_q.delete();
        rdy_set = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        send_packet(72'h00_0000_00C3_A5E1_0F74, 0, 1'b0);
        settle(1'b1);
`ifdef SPIO_SPINNAKER_LINK_RX_PARITY_EN
        send_packet(72'h00_0000_0000_0000_0030, 0, 1'b0);
        settle(1'b1);
        check("perr_no_vld", pkt_vld, 72'h0);
`endif

        // Random packets under a randomly stalling consumer.
        rdy_rand = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rv = {$urandom, $urandom, $urandom};
            rv[1] = $urandom_range(0, 1);
            send_packet(rv, (k % 4 == 0) ? 2 : 0, 1'b0);
        end
        rdy_rand = 1'b0;
        rdy_set  = 1'b1;
        repeat (4) @(posedge clk);
        settle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spio_spinnaker_link_receiver.md
Name: spio_spinnaker_link_receiver

Overview:
Receive side of the SpiNNaker link. Samples the asynchronous NRZ 2-of-7 symbol lines from a SpiNNaker chip, decodes each symbol into a nibble or EOP, and toggles ack once per accepted symbol. Assembles 40-bit or 72-bit packets and presents them on a synchronous valid/ready interface to the spio fabric. Also pulses counter strobes for delivered packets and framing errors.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages synchronising data_2of7 into clk (minimum 2).
PKT_BITS, 72 (from the shared link header), width of the packet bus.

Ports:
clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
data_2of7  input  7  asynchronous NRZ 2-of-7 symbol lines.
ack  output  1  NRZ acknowledge; toggles once per accepted symbol.
pkt_data  output  PKT_BITS  assembled packet; nibble 0 is in bits [3:0]; short packets have [71:40]=0.
pkt_vld  output  1  pkt_data is valid.
pkt_rdy  input  1  consumer accepts when pkt_vld && pkt_rdy.
ctr_pkt  output  1  one-cycle pulse per packet delivered to the output register.
ctr_flt  output  1  one-cycle pulse per framing or code error.
ctr_perr  output  1  one-cycle pulse per parity error (tied 0 without the optional feature).

Behaviour:
- Reset values: ack=0, pkt_vld=0, pkt_data=0, all ctr_* outputs=0, reference code old_code=0, state=IDLE.
- Sync and detect: data_2of7 passes through SYNC_STAGES FFs giving s.
  - diff = s ^ old_code. A symbol is present when popcount(diff) >= 2.
  - On accepting a symbol: old_code <= s; ack toggles on the same edge.
  - Minimum latency from a pin change to the ack toggle is SYNC_STAGES+1 clk.
- Decode diff using the transmitter table:
  - 0x11,0x12,0x14,0x18 -> nibbles 0-3; 0x21,0x22,0x24,0x28 -> 4-7; 0x41,0x42,0x44,0x48 -> 8-11; 0x03,0x06,0x0C,0x09 -> 12-15; 0x60 -> EOP.
  - Any other diff with popcount 2, or popcount > 2, is a code error.
- Assembly: nibble n (0-based) is written to bits [4n+3:4n]. Nibble 0 bit 1 sets long_pkt. Expected nibble count: 10 when long_pkt=0, 18 when long_pkt=1.
- States:
  - IDLE: nibble -> store it, cnt=1, go to RECV. EOP -> ack it, pulse ctr_flt, stay in IDLE. Code error -> ack, pulse ctr_flt, go to FLUSH.
  - RECV: nibble -> store, cnt+1; go to WAITEOP when cnt reaches the expected count. EOP -> early EOP: ack, pulse ctr_flt, discard, go to IDLE. Code error -> ack, pulse ctr_flt, go to FLUSH.
  - WAITEOP: EOP while the output register is free (pkt_vld=0, or pkt_rdy=1 this cycle) -> load the output register, set pkt_vld, pulse ctr_pkt, ack, go to IDLE.
    - If the EOP arrives while the output register is occupied, hold it unacked; this is the only back-pressure mechanism.
    - Nibble -> overlong packet: ack, pulse ctr_flt, go to FLUSH. Code error -> ack, pulse ctr_flt, go to FLUSH.
  - FLUSH: ack every symbol; EOP -> go to IDLE; stay in FLUSH otherwise. No further ctr_flt pulses while in FLUSH.
- Output register: pkt_vld stays high until pkt_vld && pkt_rdy. A load and a consume in the same cycle is allowed (back-to-back packets). pkt_data is stable while pkt_vld=1.
- Reset mid-packet discards the partial packet and returns ack=0 and old_code=0. After link reset the transmitter and receiver must both restart from code 0.

Optional Feature:
SPIO_SPINNAKER_LINK_RX_PARITY_EN
- Defined: at EOP acceptance, a packet whose XOR over all assembled bits is 0 (odd parity violated) is acked and dropped. pkt_vld is not set; ctr_perr pulses instead of ctr_pkt.
- Undefined: no parity check, all framed packets are delivered, ctr_perr is tied 0.

Decomposition:
- spio_spinnaker_link.h: PKT_BITS, the 2-of-7 code constants (one per nibble plus EOP), and the short and long nibble counts (10 and 18).
- Sub-module spio_spinnaker_link_sync: parameterised multi-bit FF synchroniser with asynchronous reset, reused on the transmit side for ack.

Test Plan:
1. Short packet 0x00_1234_5678 (bit1=0), with pkt_rdy=1: 10 nibbles plus EOP, each sent after the ack toggle -> exactly 11 ack toggles, pkt_vld for 1 cycle, pkt_data=0x0000000000_1234_5678 zero-extended (nibble 0 = 8), one ctr_pkt pulse.
2. Long packet 0xAB_CDEF0123_4567_89A2 (bit1=1) -> 19 ack toggles, pkt_data equal to the sent value, ctr_pkt=1 once.
3. pkt_rdy=0, then two short packets -> the first is delivered; the second's EOP is not acked (ack stable for over 100 cycles). Raising pkt_rdy -> the first packet is consumed, then the EOP is acked and the second packet is delivered.
4. Early EOP after 5 nibbles -> ctr_flt pulse, no pkt_vld, next packet received correctly. Illegal diff 0x30 -> ctr_flt pulse, FLUSH; symbols are acked until EOP, then normal reception resumes.
5. Skewed arrival (the two changing bits separated by 3 clk) -> a single symbol is decoded, with one ack toggle.
6. Assert rst after nibble 4 -> ack=0 and pkt_vld=0 immediately. A fresh packet from code 0 decodes correctly. With SPIO_SPINNAKER_LINK_RX_PARITY_EN defined, a bad-parity packet gives ctr_perr=1 and pkt_vld=0.
